// File: rtl/key_mmio_responder_if.sv
// key_mmio_responder_if: MEM-stage I/O request and load-response bundle.
// The master is the MEM stage; the slave is the key responder.
interface key_mmio_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_hit;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_hit, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_hit, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/key_mmio_responder.sv
// key_mmio_responder: push-button MMIO block (sync, debounce, DATA/EDGE/MASK).
// Define KEY_IRQ_EN to build the MASK register and the press interrupt.
module key_mmio_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_F080,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           KEY,
    key_mmio_responder_if.slave  bus,
    output logic                 irq
);
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       stable_q, stable_d;
    logic [3:0][15:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [3:0]       press;
    logic [3:0]       mask_rd;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [31:0]      rd_sel;
    logic             access, load;
    logic [1:0]       offs;
    logic             unused_bits;

    assign bus.req_hit = (bus.req_addr[31:4] == BASE_ADDR[31:4]);
    assign access      = bus.req_valid & bus.req_hit;
    assign load        = access & ~bus.req_we;
    assign offs        = bus.req_addr[3:2];
    assign unused_bits = ^{bus.req_addr[1:0], bus.req_wdata};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_MAX) stable_d[k] = sync2_q[k];
                else                     cnt_d[k]    = cnt_q[k] + 16'd1;
            end
        end
    end

    // Set wins over the clear-on-read so a coincident press is never lost.
    assign press  = stable_q & ~stable_d;
    assign edge_d = (edge_q & ~{4{load && offs == 2'd1}}) | press;

    always_comb begin
        rd_sel = 32'd0;
        unique case (offs)
            2'd0: rd_sel = {28'd0, ~stable_q};
            2'd1: rd_sel = {28'd0, edge_q};
            2'd2: rd_sel = {28'd0, mask_rd};
            2'd3: rd_sel = 32'd0;
        endcase
    end

    assign rsp_rdata_d = load ? rd_sel : rsp_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            stable_q    <= 4'hF;
            cnt_q       <= '0;
            edge_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            sync1_q     <= KEY;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            edge_q      <= edge_d;
            rsp_valid_q <= load;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef KEY_IRQ_EN
    logic [3:0] mask_q, mask_d;
    logic       irq_q;

    assign mask_d = (access && bus.req_we && offs == 2'd2)
                    ? bus.req_wdata[3:0] : mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(edge_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
    assign irq     = irq_q;
`else
    assign mask_rd = 4'd0;
    assign irq     = 1'b0;
`endif
endmodule

// File: doc/key_mmio_responder.md
# key_mmio_responder

Memory-mapped responder for the board push-buttons, serving load/store requests issued by the MEM stage. It synchronizes and debounces the four active-low `KEY` inputs, holds a debounced level register and a sticky press-event register, and returns read data one cycle after a hit. It sits beside the MEM stage at the top level, between the `KEY` pins and the MEM stage's I/O request port.

## Interface

**Parameters**
- `BASE_ADDR`, default `32'hFFFF_F080`: word-aligned base of the 16-byte register window.
- `DEBOUNCE_CYCLES`, default `50000`: number of stable cycles required before a level change is accepted; valid range 1..65535.

**Ports**
- `clk`, input, 1: single clock; all state is in this domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `KEY`, input, 4: raw buttons, asynchronous, 0 = pressed.
- `req_valid`, input, 1: MEM-stage request this cycle.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data.
- `req_hit`, output, 1: combinational; `req_addr[31:4] == BASE_ADDR[31:4]`.
- `rsp_valid`, output, 1: registered; read data valid.
- `rsp_rdata`, output, 32: registered read data.
- `irq`, output, 1: press-event interrupt (see Configuration).

## Operation

**Synchronizer.** Each `KEY` bit passes through a 2-flop synchronizer. The flops reset to 1 (released).

**Debounce.** Each key has its own 16-bit counter.
- If the synchronized value equals the stable value, the counter clears.
- Otherwise the counter increments.
- When the counter reaches `DEBOUNCE_CYCLES-1` with the values still differing, the stable value takes the synchronized value and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` never changes the stable value.

**Registers.** Offset is `req_addr[3:2]`; `req_addr[1:0]` is ignored.
- 0x0 DATA, read-only: `{28'b0, ~stable[3:0]}`, so 1 = pressed.
- 0x4 EDGE, clear-on-read: `{28'b0, edge[3:0]}`. A bit sets on a stable 1→0 transition (press). Releases do not set it.
- 0x8 MASK: read/write `mask[3:0]`; `wdata[31:4]` is ignored.
- 0xC: reads 0.
- Stores to DATA, EDGE and 0xC are ignored.

**Transactions.**
- An access occurs when `req_valid & req_hit`.
- A load registers the selected value into `rsp_rdata` and sets `rsp_valid` for exactly one cycle.
- A store updates on the clock edge and produces no response.
- A miss produces no response and changes no state.

**Collision.** If a load of EDGE coincides with a new press event on bit k:
- the returned value shows the prior `edge[k]`;
- `edge[k]` ends at 1, because set wins over clear.

**Back-to-back.** Loads issued on consecutive cycles each get a response on consecutive cycles. There is no stall and no backpressure.

**Reset values.**
- Synchronizer flops and stable values: 4'hF.
- Counters: 0.
- `edge`: 0. `mask`: 0.
- `rsp_valid`: 0. `rsp_rdata`: 0. `irq`: 0.
- An assertion of `reset_n` mid-debounce or mid-response discards all state immediately, asynchronously.

## Timing

- Load latency is 1 cycle. A request at edge N produces `rsp_valid`/`rsp_rdata` after edge N+1, held for one cycle only.
- Pin to DATA latency for a clean transition is 2 synchronizer cycles plus `DEBOUNCE_CYCLES` cycles.
- An EDGE bit sets in the same cycle the stable value changes.
- `irq` is registered and follows `edge & mask` with a 1-cycle delay.
- A MASK store is visible to a load on the next cycle.

## Configuration

- `KEY_IRQ_EN` defined: the MASK register exists and `irq` is registered `|(edge & mask)`.
- `KEY_IRQ_EN` undefined:
  - no mask flops;
  - MASK reads 0 and stores to it are ignored;
  - `irq` is tied to 0.
- DATA/EDGE behaviour is identical in both builds.

## Test plan

Use `DEBOUNCE_CYCLES=4` and `BASE_ADDR=32'hFFFF_F080` in sim.

- **Debounced press:** `KEY` = 4'b1110 held 10 cycles, then load 0xFFFFF080 → `rsp_rdata`=32'h1; load 0xFFFFF084 → 32'h1; second load 0xFFFFF084 → 32'h0.
- **Glitch rejection:** KEY[2] low for 3 cycles, then high → DATA stays 0 and EDGE stays 0.
- **Collision:** arrange KEY[1]'s stable value to fall in the same cycle as a load of 0xFFFFF084 with `edge`=4'b0001 → `rsp_rdata`=32'h1; the following EDGE load → 32'h2.
- **Interrupt (`KEY_IRQ_EN` defined):** store 32'h8 to 0xFFFFF088, then press KEY[3] → `irq`=1 one cycle after `edge[3]` sets; a load of EDGE returns 32'h8, then `irq`=0 one cycle later. Without the macro, `irq` stays 0 and MASK reads 0.
- **Miss and back-to-back:**
  - load 0xFFFFF090 → `req_hit`=0, no `rsp_valid`;
  - loads at 0x080 then 0x088 on consecutive cycles → two consecutive `rsp_valid` pulses with the matching data.
- **Async reset:** drop `reset_n` mid-debounce with KEY[0] low for 2 cycles → all outputs 0 immediately; after release, DATA reads 0 until a full 2+4 cycles of KEY[0] low have elapsed.
